regs_file: RTL
==============

Name: regs_file

Overview:
- Integer register file x0..x31 for the single-issue RISC-V core.
- Responder side of the decode stage's register-read interface: decode drives rs1/rs2 addresses and consumes rs1/rs2 data combinationally in the same cycle.
- Write port is driven by execute/writeback with rd address, data and write enable.
- A post-reset init sequencer clears x1..x31, one per cycle, so the array can map to distributed RAM without a parallel reset.

Parameters:
- XLEN, 32, data width of each register.
- REG_AW, 5, register address width (32 entries).
- BYPASS_EN, 1, 1 = same-cycle write-to-read forwarding on both read ports; 0 = read returns array contents only.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rs1_addr_i  input  REG_AW  read port 1 address, from decode.
- rs2_addr_i  input  REG_AW  read port 2 address, from decode.
- rs1_data_o  output  XLEN  read port 1 data, combinational.
- rs2_data_o  output  XLEN  read port 2 data, combinational.
- reg_wen_i  input  1  write enable, from execute.
- rd_addr_i  input  REG_AW  write address.
- rd_data_i  input  XLEN  write data.
- ready_o  output  1  registered; high once init clear is complete and writes are accepted.

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high (rst). No asynchronous reset anywhere.
- State machine has two states, INIT and RUN, plus a clear_idx counter of REG_AW bits.
- At a rising edge with rst=1: state<=INIT, clear_idx<=1, ready_o<=0. Array contents are not reset in parallel.
- INIT, each edge: regs[clear_idx]<=0, clear_idx<=clear_idx+1.
  - At the edge where clear_idx==31: write regs[31]<=0, state<=RUN, ready_o<=1.
  - INIT therefore lasts exactly 31 edges after the reset edge. ready_o rises at edge 31 after rst deasserts.
- INIT, other rules:
  - reg_wen_i is ignored; the write is dropped, not queued.
  - Both read ports return 0 regardless of address.
  - Upstream must stall until ready_o=1.
- RUN, write: at an edge with reg_wen_i=1 and rd_addr_i!=0, regs[rd_addr_i]<=rd_data_i. A write to x0 is discarded.
- RUN, read priority for each port independently:
  - addr==0 -> 0.
  - Else if BYPASS_EN and reg_wen_i and rd_addr_i==addr -> rd_data_i.
  - Else -> regs[addr].
- Read latency is 0 cycles (combinational). Write latency is 1 edge without bypass, 0 with bypass.
- Both ports reading the write address in the same cycle: both get rd_data_i.
- rs1_addr_i==rs2_addr_i is legal; both outputs are identical.
- rst asserted mid-RUN: return to INIT and clear fully. A write presented on the rst edge is dropped.
- rst held high for multiple cycles: stays at INIT with clear_idx=1, no clearing progress.
- clear_idx wraps 31->0 only on the INIT->RUN edge; its value in RUN is don't-care and it is frozen.
- x0 is never stored. Reading address 0 is a constant 0 in every state.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN=32, REG_AW=5, NUM_REGS=32, REG_ZERO=5'd0.
  - Enum rf_state_t {RF_INIT, RF_RUN}.
- Decode and execute already use the same widths, so these constants are imported by id, ex and regs_file.
- No sub-module: the read mux is duplicated per port via a function in the module. The init FSM is about 20 lines and stays inline.

Test Plan:
- Reset release: rst high 2 cycles, then low. Require ready_o=0 for 30 edges and ready_o=1 at edge 31. During INIT, read addr 5 returns 0 and reg_wen_i=1 to x5 with data 0xDEADBEEF has no effect. After ready_o, read x5 returns 0.
- Basic write/read: write x3=0x00000010 (BYPASS_EN=0). Read rs1=x3 in the same cycle returns 0. Next cycle it returns 0x00000010, and rs2=x3 also returns 0x00000010.
- Bypass: BYPASS_EN=1, x7 holds 0x11111111. Write x7=0x22222222 with rs1=rs2=x7 in the same cycle. Both outputs show 0x22222222 in that cycle and still show it after the edge.
- x0 protection: write x0=0xFFFFFFFF with rs1=x0, rs2=x0. Both read 0 in that cycle and the next, including with bypass enabled.
- Reset mid-operation: fill x1..x31 with their index values, assert rst for 1 cycle together with a write x9=0xABCD. Require ready_o to fall, 31 INIT edges to follow, and all of x1..x31 to read 0 after ready_o. x9 must not read 0xABCD.
- Back-to-back writes: write x1=1, x2=2 and x1=3 on consecutive edges while reading x1 and x2 each cycle. Expected read sequence, with bypass: x1=1,1,3 and x2=0,2,2.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core constants and register-file types.
// Imported by decode, execute and regs_file so all stages agree on widths.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    // Register-file control: post-reset clearing, then normal operation.
    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regs_file.sv
// Integer register file x0..x31 for the single-issue core.
// Two combinational read ports (decode side), one write port (execute side).
// After reset an init sequencer clears x1..x31 one per cycle so the array
// needs no parallel reset and can map onto distributed RAM.
//
// Ports:
//   clk         core clock, rising edge
//   rst         synchronous active-high reset
//   rs1_addr_i  read port 1 address
//   rs2_addr_i  read port 2 address
//   rs1_data_o  read port 1 data (combinational)
//   rs2_data_o  read port 2 data (combinational)
//   reg_wen_i   write enable
//   rd_addr_i   write address
//   rd_data_i   write data
//   ready_o     registered; high once clearing is done and writes are accepted
module regs_file #(
    parameter int unsigned XLEN      = riscv_pkg::XLEN,
    parameter int unsigned REG_AW    = riscv_pkg::REG_AW,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    output logic [XLEN-1:0]   rs1_data_o,
    output logic [XLEN-1:0]   rs2_data_o,
    input  logic              reg_wen_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic [XLEN-1:0]   rd_data_i,
    output logic              ready_o
);

    import riscv_pkg::*;

    localparam int unsigned    DEPTH    = 2 ** REG_AW;
    localparam logic [REG_AW-1:0] ADDR_ZERO = REG_AW'(REG_ZERO);
    localparam logic [REG_AW-1:0] ADDR_LAST = REG_AW'(DEPTH - 1);

    logic [XLEN-1:0]   regs [DEPTH];

    rf_state_t         state;
    rf_state_t         state_nxt;
    logic [REG_AW-1:0] clear_idx;
    logic [REG_AW-1:0] clear_idx_nxt;
    logic              ready_nxt;
    logic              clear_we;
    logic              wr_we;

    // State register: control state, clear pointer and ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RF_INIT;
            clear_idx <= REG_AW'(1);
            ready_o   <= 1'b0;
        end else begin
            state     <= state_nxt;
            clear_idx <= clear_idx_nxt;
            ready_o   <= ready_nxt;
        end
    end

    // Next state: leave INIT on the edge that clears the last register.
    always_comb begin
        state_nxt = state;
        case (state)
            RF_INIT: if (clear_idx == ADDR_LAST) state_nxt = RF_RUN;
            RF_RUN:  state_nxt = RF_RUN;
            default: state_nxt = RF_INIT;
        endcase
    end

    // Outputs of the FSM: clear strobe, pointer advance, gated write, ready.
    // The pointer wraps to 0 on the INIT->RUN edge and then stays frozen.
    always_comb begin
        clear_we      = 1'b0;
        clear_idx_nxt = clear_idx;
        wr_we         = 1'b0;
        ready_nxt     = (state_nxt == RF_RUN);
        if (state == RF_INIT) begin
            clear_we      = 1'b1;
            clear_idx_nxt = clear_idx + REG_AW'(1);
        end else begin
            wr_we = reg_wen_i && (rd_addr_i != ADDR_ZERO);
        end
    end

    // Array storage; no reset so it can sit in distributed RAM.
    // Writes arriving on a reset edge or during INIT are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clear_we) begin
                regs[clear_idx] <= '0;
            end else if (wr_we) begin
                regs[rd_addr_i] <= rd_data_i;
            end
        end
    end

    // Per-port read priority: x0 / INIT -> 0, then same-cycle write, then array.
    function automatic logic [XLEN-1:0] read_mux(
        input logic              run,
        input logic [REG_AW-1:0] addr,
        input logic              wen,
        input logic [REG_AW-1:0] waddr,
        input logic [XLEN-1:0]   wdata,
        input logic [XLEN-1:0]   stored
    );
        if (!run || (addr == ADDR_ZERO)) begin
            return '0;
        end else if (BYPASS_EN && wen && (waddr == addr)) begin
            return wdata;
        end
        return stored;
    endfunction

    assign rs1_data_o = read_mux(state == RF_RUN, rs1_addr_i, reg_wen_i,
                                 rd_addr_i, rd_data_i, regs[rs1_addr_i]);
    assign rs2_data_o = read_mux(state == RF_RUN, rs2_addr_i, reg_wen_i,
                                 rd_addr_i, rd_data_i, regs[rs2_addr_i]);

endmodule
